// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator core and its feeder.
package acc_pkg;

  // Defaults that match the accumulator core's number/result widths
  localparam int ACC_IN_DATA_WIDTH = 8;
  localparam int ACC_DWIDTH        = ACC_IN_DATA_WIDTH * 4;

  // Feeder control FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/acc_feeder_if.sv
// Operand-buffer read port plus accumulator drive/observe signals.
// The master modport is the feeder side; the slave modport is the buffer/accumulator side.
interface acc_feeder_if #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int DWIDTH        = IN_DATA_WIDTH * 4,
  parameter int ADDR_WIDTH    = 8
);
  logic                     rd_en_o;
  logic [ADDR_WIDTH-1:0]    rd_addr_o;
  logic [IN_DATA_WIDTH-1:0] rd_data_i;
  logic                     acc_run_o;
  logic                     acc_valid_o;
  logic [IN_DATA_WIDTH-1:0] acc_number_o;
  logic                     acc_valid_i;
  logic [DWIDTH-1:0]        acc_result_i;

  modport master (
    output rd_en_o, rd_addr_o, acc_run_o, acc_valid_o, acc_number_o,
    input  rd_data_i, acc_valid_i, acc_result_i
  );

  modport slave (
    input  rd_en_o, rd_addr_o, acc_run_o, acc_valid_o, acc_number_o,
    output rd_data_i, acc_valid_i, acc_result_i
  );
endinterface

// File: rtl/acc_feeder.sv
// acc_feeder: reads N operands from a sync buffer, clears the accumulator,
// streams the operands into it and captures the final sum.
// Optional build macro: ACC_FEEDER_CHK_EN adds err_o and a shadow-sum check.
module acc_feeder
  import acc_pkg::*;
#(
  parameter int IN_DATA_WIDTH = ACC_IN_DATA_WIDTH,
  parameter int DWIDTH        = IN_DATA_WIDTH * 4,
  parameter int ADDR_WIDTH    = 8,
  parameter int CNT_WIDTH     = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  num_cnt_i,
  output logic                  idle_o,
  output logic                  done_o,
  output logic [DWIDTH-1:0]     result_o,
`ifdef ACC_FEEDER_CHK_EN
  output logic                  err_o,
`endif
  acc_feeder_if.master          bus
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;       // reads still to issue
  logic                  vld_q, vld_d;       // rd_en delayed onto acc_valid
  logic [1:0]            last_q, last_d;     // [0] aligned to acc_valid, [1] to acc output
  logic [DWIDTH-1:0]     result_q, result_d;
  logic                  rd_en;
  logic                  capture;

  assign rd_en   = (state_q == ST_READ);
  assign capture = last_q[1];

  // Next-state, address/count and capture logic
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    vld_d    = rd_en;
    last_d   = {last_q[0], rd_en && (cnt_q == CNT_WIDTH'(1))};
    case (state_q)
      ST_IDLE: if (start_i) begin
        state_d = ST_CLEAR;
        addr_d  = base_addr_i;
        cnt_d   = num_cnt_i;
      end
      ST_CLEAR: begin
        if (cnt_q == '0) begin
          state_d  = ST_DONE;
          result_d = '0;       // empty run reports a zero sum
        end else begin
          state_d  = ST_READ;
        end
      end
      ST_READ: begin
        addr_d = addr_q + ADDR_WIDTH'(1);   // wraps modulo 2^ADDR_WIDTH
        cnt_d  = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (capture) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Capture follows the delayed last-tag alone, not the accumulator's valid
    if (capture) result_d = bus.acc_result_i;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      last_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      last_q   <= last_d;
      result_q <= result_d;
    end
  end

  assign idle_o           = (state_q == ST_IDLE);
  assign done_o           = (state_q == ST_DONE);
  assign result_o         = result_q;
  assign bus.rd_en_o      = rd_en;
  assign bus.rd_addr_o    = addr_q;
  assign bus.acc_run_o    = (state_q == ST_CLEAR);
  assign bus.acc_valid_o  = vld_q;
  // Buffer data lands one cycle after rd_en, exactly when vld_q is high
  assign bus.acc_number_o = vld_q ? bus.rd_data_i : '0;

`ifdef ACC_FEEDER_CHK_EN
  logic [DWIDTH-1:0] shadow_q, shadow_d;
  logic              err_q, err_d;

  // Shadow sum of streamed operands, compared against the core at capture
  always_comb begin
    shadow_d = shadow_q;
    err_d    = err_q;
    if (state_q == ST_CLEAR) begin
      shadow_d = '0;
      if (cnt_q == '0) err_d = 1'b0;
    end else if (vld_q) begin
      shadow_d = shadow_q + DWIDTH'(bus.acc_number_o);
    end
    if (capture) err_d = !bus.acc_valid_i || (bus.acc_result_i != shadow_q);
  end

  // Shadow/err registers
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_acc_valid;
  assign unused_acc_valid = bus.acc_valid_i;
`endif

endmodule

// File: tb/tb_acc_feeder.sv
// Directed bench for acc_feeder with a behavioural sync buffer and accumulator.
module tb_acc_feeder;
  localparam int IW = 8;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [CW-1:0] num_cnt_i;
  logic          idle_o;
  logic          done_o;
  logic [DW-1:0] result_o;
`ifdef ACC_FEEDER_CHK_EN
  logic          err_o;
`endif

  acc_feeder_if #(.IN_DATA_WIDTH(IW), .DWIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  acc_feeder #(.IN_DATA_WIDTH(IW), .DWIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .num_cnt_i   (num_cnt_i),
    .idle_o      (idle_o),
    .done_o      (done_o),
    .result_o    (result_o),
`ifdef ACC_FEEDER_CHK_EN
    .err_o       (err_o),
`endif
    .bus         (bus_if.master)
  );

  always #5 clk = ~clk;

  // Operand buffer: synchronous read, data one cycle after rd_en
  logic [IW-1:0] mem [256];
  always @(posedge clk) if (bus_if.rd_en_o) bus_if.rd_data_i <= mem[bus_if.rd_addr_o];

  // Accumulator: run clears, valid adds, registered result/valid
  logic [DW-1:0] acc_sum  = '0;
  logic          acc_vout = 1'b0;
  logic [DW-1:0] acc_bias = '0;
  always @(posedge clk) begin
    if (bus_if.acc_run_o)        acc_sum <= '0;
    else if (bus_if.acc_valid_o) acc_sum <= acc_sum + DW'(bus_if.acc_number_o);
    acc_vout <= bus_if.acc_valid_o && !bus_if.acc_run_o;
  end
  assign bus_if.acc_result_i = acc_sum + acc_bias;
  assign bus_if.acc_valid_i  = acc_vout;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One run started at cycle 0; samples every cycle on the falling edge.
  // rst_at > 0 pulses reset during that cycle and checks the abort.
  task automatic run(input logic [AW-1:0] base, input int n, input logic [DW-1:0] exp,
                     input bit exp_err, input bit hold, input int rst_at);
    int done_c = (n == 0) ? 2 : n + 4;
    int idle_c = done_c + 1;
    logic [AW-1:0] a;
    start_i     = 1'b1;
    base_addr_i = base;
    num_cnt_i   = CW'(n);
    for (int c = 1; c <= idle_c; c++) begin
      @(negedge clk);
      chk("run", bus_if.acc_run_o, c == 1);
      chk("rd_en", bus_if.rd_en_o, c >= 2 && c <= n + 1);
      if (c >= 2 && c <= n + 1) begin
        a = base + AW'(c - 2);
        chk("rd_addr", bus_if.rd_addr_o, a);
      end
      chk("acc_valid", bus_if.acc_valid_o, c >= 3 && c <= n + 2);
      if (c >= 3 && c <= n + 2) begin
        a = base + AW'(c - 3);
        chk("acc_number", bus_if.acc_number_o, mem[a]);
      end
      chk("done", done_o, c == done_c);
      if (c == done_c) begin
        chk("result", result_o, exp);
`ifdef ACC_FEEDER_CHK_EN
        chk("err", err_o, exp_err);
`else
        if (exp_err) $display("note: err expectation ignored without checker");
`endif
      end
      chk("idle", idle_o, c == idle_c);
      if (!hold) start_i = 1'b0;
      if (c == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_idle", idle_o, 1'b1);
        chk("rst_outs", {done_o, bus_if.rd_en_o, bus_if.acc_run_o, bus_if.acc_valid_o}, 4'b0);
        chk("rst_data", {bus_if.rd_addr_o, bus_if.acc_number_o, result_o}, '0);
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          chk("no_done", done_o, 1'b0);
        end
        return;
      end
    end
    if (hold) begin
      // start still high once idle: a fresh run begins only now
      @(negedge clk);
      chk("hold_rerun", bus_if.acc_run_o, 1'b1);
      start_i = 1'b0;
      for (int k = 0; k < n + 6; k++) @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; base_addr_i = '0; num_cnt_i = '0;
    bus_if.rd_data_i = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_idle", idle_o, 1'b1);
    chk("reset_outs", {done_o, bus_if.rd_en_o, bus_if.acc_run_o, bus_if.acc_valid_o}, 4'b0);
    chk("reset_data", {bus_if.rd_addr_o, bus_if.acc_number_o, result_o}, '0);
    reset = 1'b0;
    @(negedge clk);

    // base 0x10, N=4, data 1..4 -> 10
    mem[8'h10] = 8'd1; mem[8'h11] = 8'd2; mem[8'h12] = 8'd3; mem[8'h13] = 8'd4;
    run(8'h10, 4, 32'd10, 1'b0, 1'b0, 0);
    @(negedge clk);

    // N=0 -> no reads, zero result at cycle 2
    run(8'h10, 0, 32'd0, 1'b0, 1'b0, 0);
    @(negedge clk);

    // address wrap FE,FF,00,01 -> 26
    mem[8'hFE] = 8'd5; mem[8'hFF] = 8'd6; mem[8'h00] = 8'd7; mem[8'h01] = 8'd8;
    run(8'hFE, 4, 32'd26, 1'b0, 1'b0, 0);
    @(negedge clk);

    // start held through an N=3 run of ones -> one done, result 3
    mem[8'h30] = 8'd1; mem[8'h31] = 8'd1; mem[8'h32] = 8'd1;
    run(8'h30, 3, 32'd3, 1'b0, 1'b1, 0);
    @(negedge clk);

    // reset at cycle 4 of an N=8 run, then a fresh N=2 run of 9s -> 18
    for (int i = 0; i < 8; i++) mem[8'h20 + i] = 8'd3;
    run(8'h20, 8, 32'd0, 1'b0, 1'b0, 4);
    mem[8'h40] = 8'd9; mem[8'h41] = 8'd9;
    run(8'h40, 2, 32'd18, 1'b0, 1'b0, 0);
    @(negedge clk);

`ifdef ACC_FEEDER_CHK_EN
    // full-depth run of 0xFF -> 65280, no error
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    run(8'h00, 256, 32'd65280, 1'b0, 1'b0, 0);
    @(negedge clk);
    // corrupted accumulator output -> captured value is off by one, err set
    acc_bias = 32'd1;
    run(8'h00, 3, 32'd766, 1'b1, 1'b0, 0);
    acc_bias = 32'd0;
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
